// File: rtl/lbm_pkg.sv
// Shared lattice definitions: direction ordering, per-direction unit steps and
// the writer's state encoding.
package lbm_pkg;

    typedef enum logic [3:0] {
        DIR_C, DIR_N, DIR_NE, DIR_E, DIR_SE, DIR_S, DIR_SW, DIR_W, DIR_NW
    } dir_e;

    localparam int NUM_DIRS = 9;

    typedef logic signed [1:0] step_t;

    localparam step_t STEP_NEG  = 2'sb11;
    localparam step_t STEP_ZERO = 2'sb00;
    localparam step_t STEP_POS  = 2'sb01;

    // North is vert-1, east is hor+1.
    localparam step_t DIR_DX [NUM_DIRS] = '{
        STEP_ZERO, STEP_ZERO, STEP_POS, STEP_POS, STEP_POS,
        STEP_ZERO, STEP_NEG,  STEP_NEG, STEP_NEG
    };
    localparam step_t DIR_DY [NUM_DIRS] = '{
        STEP_ZERO, STEP_NEG, STEP_NEG, STEP_ZERO, STEP_POS,
        STEP_POS,  STEP_POS, STEP_ZERO, STEP_NEG
    };

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACTIVE = 2'd1;
    localparam state_t ST_DRAIN  = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

endpackage

// File: rtl/stream_push_writer_if.sv
// Cell input stream and per-direction BRAM write bus of the push writer.
interface stream_push_writer_if #(
    parameter int HPIXELS    = 4,
    parameter int VPIXELS    = 3,
    parameter int DATA_WIDTH = 16
);
    localparam int HOR_SIZE  = $clog2(HPIXELS);
    localparam int VERT_SIZE = $clog2(VPIXELS);
    localparam int BRAM_SIZE = $clog2(HPIXELS * VPIXELS);

    logic                              valid_in;
    logic                              ready_out;
    logic [HOR_SIZE-1:0]               hor_in;
    logic [VERT_SIZE-1:0]              vert_in;
    logic [8:0][DATA_WIDTH-1:0]        f_in;
    logic [8:0]                        we_out;
    logic [8:0][BRAM_SIZE-1:0]         addr_out;
    logic [8:0][DATA_WIDTH-1:0]        data_out;

    modport master (
        output valid_in, hor_in, vert_in, f_in,
        input  ready_out, we_out, addr_out, data_out
    );

    modport slave (
        input  valid_in, hor_in, vert_in, f_in,
        output ready_out, we_out, addr_out, data_out
    );

endinterface

// File: rtl/neighbor_wrap.sv
// Combinational neighbor address: steps (hor, vert) by (dx, dy) with periodic
// wrap and returns vert*HPIXELS + hor.
module neighbor_wrap
    import lbm_pkg::*;
#(
    parameter int HPIXELS = 4,
    parameter int VPIXELS = 3,
    localparam int HOR_SIZE  = $clog2(HPIXELS),
    localparam int VERT_SIZE = $clog2(VPIXELS),
    localparam int BRAM_SIZE = $clog2(HPIXELS * VPIXELS)
) (
    input  logic [HOR_SIZE-1:0]  hor_in,
    input  logic [VERT_SIZE-1:0] vert_in,
    input  step_t                dx_in,
    input  step_t                dy_in,
    output logic [BRAM_SIZE-1:0] addr_out
);

    logic [HOR_SIZE-1:0]  hor_n;
    logic [VERT_SIZE-1:0] vert_n;

    always_comb begin
        hor_n = hor_in;
        if (dx_in == STEP_POS) begin
            hor_n = (hor_in == HOR_SIZE'(HPIXELS - 1)) ? '0 : hor_in + HOR_SIZE'(1);
        end else if (dx_in == STEP_NEG) begin
            hor_n = (hor_in == '0) ? HOR_SIZE'(HPIXELS - 1) : hor_in - HOR_SIZE'(1);
        end
    end

    always_comb begin
        vert_n = vert_in;
        if (dy_in == STEP_POS) begin
            vert_n = (vert_in == VERT_SIZE'(VPIXELS - 1)) ? '0 : vert_in + VERT_SIZE'(1);
        end else if (dy_in == STEP_NEG) begin
            vert_n = (vert_in == '0) ? VERT_SIZE'(VPIXELS - 1) : vert_in - VERT_SIZE'(1);
        end
    end

    assign addr_out = BRAM_SIZE'(vert_n) * BRAM_SIZE'(HPIXELS) + BRAM_SIZE'(hor_n);

endmodule

// File: rtl/pipeline.sv
// Fixed-depth register delay line; reset clears every stage so nothing in
// flight survives a reset.
module pipeline #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_out
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= d_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_out = stage_q[DEPTH-1];

endmodule

// File: rtl/stream_push_writer.sv
// Streaming write side: pushes each accepted cell's nine values to their
// wrapped neighbor addresses and sequences one frame sweep per start.
//
// state  | meaning
// IDLE   | waiting for start_in
// ACTIVE | accepting cells until HPIXELS*VPIXELS have been taken
// DRAIN  | letting the last LATENCY writes leave the pipeline
// DONE   | one cycle; frame_done_out and bank flip on leaving
module stream_push_writer
    import lbm_pkg::*;
#(
    parameter int HPIXELS    = 4,
    parameter int VPIXELS    = 3,
    parameter int DATA_WIDTH = 16,
    parameter int LATENCY    = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_in,
    stream_push_writer_if.slave  bus,
    output logic                 bank_out,
    output logic                 busy_out,
    output logic                 frame_done_out,
    output logic                 error_out
);

    localparam int HOR_SIZE  = $clog2(HPIXELS);
    localparam int VERT_SIZE = $clog2(VPIXELS);
    localparam int BRAM_SIZE = $clog2(HPIXELS * VPIXELS);
    localparam int N_CELLS   = HPIXELS * VPIXELS;
    localparam int CNT_W     = $clog2(N_CELLS + 1);
    localparam int DRN_W     = $clog2(LATENCY + 1);
    localparam int PIPE_W    = 9 * (1 + BRAM_SIZE + DATA_WIDTH);

    localparam logic [HOR_SIZE:0]  HP_LIM = (HOR_SIZE + 1)'(HPIXELS);
    localparam logic [VERT_SIZE:0] VP_LIM = (VERT_SIZE + 1)'(VPIXELS);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DRN_W-1:0]   drain_q, drain_d;
    logic               bank_q, bank_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               ready;
    logic               accept;
    logic               in_range;
    logic               last_cell;
    logic [8:0]                  we_d;
    logic [8:0][BRAM_SIZE-1:0]   nb_addr;
    logic [PIPE_W-1:0]           pipe_d, pipe_q;

    assign ready     = (state_q == ST_ACTIVE);
    assign accept    = bus.valid_in & ready;
    assign in_range  = ({1'b0, bus.hor_in} < HP_LIM) && ({1'b0, bus.vert_in} < VP_LIM);
    assign last_cell = (cnt_q == CNT_W'(N_CELLS - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        bank_d  = bank_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = '0;
                end
            end
            ST_ACTIVE: begin
                if (accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (!in_range) err_d = 1'b1;
                    if (last_cell) begin
                        state_d = ST_DRAIN;
                        drain_d = DRN_W'(LATENCY - 1);
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) state_d = ST_DONE;
                else               drain_d = drain_q - DRN_W'(1);
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                bank_d  = ~bank_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            drain_q <= '0;
            bank_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            bank_q  <= bank_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    for (genvar i = 0; i < NUM_DIRS; i++) begin : g_dir
        neighbor_wrap #(
            .HPIXELS (HPIXELS),
            .VPIXELS (VPIXELS)
        ) u_wrap (
            .hor_in   (bus.hor_in),
            .vert_in  (bus.vert_in),
            .dx_in    (DIR_DX[i]),
            .dy_in    (DIR_DY[i]),
            .addr_out (nb_addr[i])
        );
    end

    // Idle cycles push zeros so the write bus reads back as zero between strobes.
    assign we_d   = {9{in_range}};
    assign pipe_d = accept ? {we_d, nb_addr, bus.f_in} : '0;

    pipeline #(
        .WIDTH (PIPE_W),
        .DEPTH (LATENCY)
    ) u_pipe (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .d_in   (pipe_d),
        .q_out  (pipe_q)
    );

    assign {bus.we_out, bus.addr_out, bus.data_out} = pipe_q;
    assign bus.ready_out  = ready;
    assign bank_out       = bank_q;
    assign busy_out       = (state_q != ST_IDLE);
    assign frame_done_out = done_q;
    assign error_out      = err_q;

endmodule
